// File: rtl/rf_pkg.sv
// Shared definitions for the 2-read/1-write register file and its decoder.
// Defaults describe the Simple RISC Machine: eight 16-bit registers.
package rf_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    // Register count for a given register-number width.
    function automatic int nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Register number as seen by the decoder with the default geometry.
    typedef logic [DEF_ADDR_W-1:0] regnum_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for registers waiting on a memory load.
// A lock sets a bit, a write clears it, and a lock wins a same-register collision.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              lock,
    input  logic [ADDR_W-1:0] locknum,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy
);

    localparam int NREGS = nregs(ADDR_W);

    logic [NREGS-1:0]       busy_q;
    logic [NREGS-1:0]       busy_d;
    logic                   clr_en;
    logic                   set_en;
    logic [1:0][ADDR_W-1:0] rd_sel;
    logic [1:0]             busy_rd;

    assign clr_en = write && !((ZERO_R0 != 0) && (writenum == '0));
    assign set_en = lock  && !((ZERO_R0 != 0) && (locknum  == '0));

    // Set is applied after clear so a colliding lock leaves the bit at 1.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[writenum] = 1'b0;
        end
        if (set_en) begin
            busy_d[locknum] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd_sel = {readnum_b, readnum_a};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic r0_hit;
            logic byp_hit;

            assign r0_hit  = (ZERO_R0 != 0) && (rd_sel[gi] == '0);
            assign byp_hit = (BYPASS != 0) && write && (writenum == rd_sel[gi]);

            // A forwarded write reports the post-edge busy state of its register.
            assign busy_rd[gi] = reset_n && !r0_hit &&
                                 (byp_hit ? (lock && (locknum == writenum))
                                          : busy_q[rd_sel[gi]]);
        end
    endgenerate

    assign busy_a   = busy_rd[0];
    assign busy_b   = busy_rd[1];
    assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Two combinational read ports, one synchronous write port, optional
// write-to-read forwarding, optional hardwired-zero R0 and a load scoreboard.
module regfile_2r1w
    import rf_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] readnum_a,
    output logic [DATA_W-1:0] data_out_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_b,
    input  logic              lock,
    input  logic [ADDR_W-1:0] locknum,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy
);

    localparam int NREGS = nregs(ADDR_W);

    logic [DATA_W-1:0]      regs_q [NREGS];
    logic [DATA_W-1:0]      regs_d [NREGS];
    logic                   wr_en;
    logic [1:0][ADDR_W-1:0] rd_sel;
    logic [1:0][DATA_W-1:0] rd_data;

    // With a hardwired R0 its flop is never written, so it stays at its reset value.
    assign wr_en = write && !((ZERO_R0 != 0) && (writenum == '0));

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[writenum] = data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_sel = {readnum_b, readnum_a};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic r0_hit;
            logic byp_hit;

            assign r0_hit  = (ZERO_R0 != 0) && (rd_sel[gi] == '0);
            assign byp_hit = (BYPASS != 0) && write && (writenum == rd_sel[gi]);

            // Outputs are forced low while reset is held, even if a forwarded write is pending.
            assign rd_data[gi] = (!reset_n || r0_hit) ? '0 :
                                 byp_hit              ? data_in :
                                                        regs_q[rd_sel[gi]];
        end
    endgenerate

    assign data_out_a = rd_data[0];
    assign data_out_b = rd_data[1];

    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .write     (write),
        .writenum  (writenum),
        .lock      (lock),
        .locknum   (locknum),
        .readnum_a (readnum_a),
        .readnum_b (readnum_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .any_busy  (any_busy)
    );

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised successor to the single-port register file for the Simple RISC Machine datapath. It provides two independent combinational read ports and one synchronous write port. It adds optional write-to-read bypass, an optional hardwired-zero R0, and a per-register busy scoreboard for pending memory loads. It sits between the decoder (read/write register numbers) and the ALU operand latches, and takes writeback from the ALU/memory mux.

Parameters:
DATA_W, 16, register and data bus width in bits (>=1)
ADDR_W, 3, register-number width; register count NREGS = 2**ADDR_W
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding
ZERO_R0, 0, 1 = R0 reads as 0, and writes/locks to R0 are ignored

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
write  input  1  write enable for the write port
writenum  input  ADDR_W  destination register of the write
data_in  input  DATA_W  write data
readnum_a  input  ADDR_W  read port A register select
data_out_a  output  DATA_W  read port A data
readnum_b  input  ADDR_W  read port B register select
data_out_b  output  DATA_W  read port B data
lock  input  1  marks register locknum busy (load issued)
locknum  input  ADDR_W  register to mark busy
busy_a  output  1  register selected by readnum_a is busy
busy_b  output  1  register selected by readnum_b is busy
any_busy  output  1  OR of all busy bits

Behaviour:
- Reset (reset_n=0, async, takes effect immediately, including mid-operation):
  - all NREGS registers clear to 0; all busy bits clear to 0.
  - data_out_a/b = 0; busy_a/b = 0; any_busy = 0 while reset is held.
  - writes and locks are ignored while reset_n=0.
- Write (posedge clk, write=1): reg[writenum] <= data_in; busy[writenum] <= 0 unless a lock to the same register occurs in the same cycle.
- Lock (posedge clk, lock=1): busy[locknum] <= 1.
- Simultaneous write and lock to the same register: the data is written and busy ends at 1. Lock wins because it represents a newer pending load.
- Simultaneous write and lock to different registers: both take effect.
- Reads are combinational; zero-cycle latency from readnum_x to data_out_x.
- Both ports may select the same register; each returns identical data.
- BYPASS=1: if write=1 and writenum==readnum_x, data_out_x = data_in in the same cycle. busy_x = 0 in that cycle unless lock=1 and locknum==writenum.
- BYPASS=0: written value becomes visible on the read ports the cycle after the edge. busy_x reflects stored busy bits only.
- busy_a = busy[readnum_a], busy_b = busy[readnum_b] (subject to the bypass rule above).
- any_busy is the OR of stored busy bits and is not bypassed.
- ZERO_R0=1:
  - reg[0] is constant 0; writes to R0 are discarded and lock to R0 is ignored.
  - reads of R0 return 0 with busy 0, and bypass never applies to R0.
- Arithmetic: none. Every 2**ADDR_W address is valid, so there is no out-of-range case.
- Write with write=0 or lock with lock=0: no state change regardless of writenum/locknum/data_in.

Decomposition:
- Shared package rf_pkg:
  - default DATA_W/ADDR_W constants.
  - localparam function for NREGS.
  - typedef for the register-number type, reused by the decoder.
- One natural sub-module, rf_scoreboard: the busy-bit vector with set (lock) / clear (write) priority logic, busy lookups and any_busy.
- The storage array and read muxes stay in regfile_2r1w.

Test Plan:
- Reset: load R3=16'h1234, pulse reset_n low mid-cycle -> data_out_a reads 0 immediately for all registers; any_busy=0.
- Dual read: write R1=16'hABCD, R6=16'h0F0F -> next cycle readnum_a=1, readnum_b=6 gives ABCD/0F0F. Both ports at 6 give 0F0F/0F0F.
- Bypass: with BYPASS=1, write R2=16'h5555 while readnum_a=2 -> data_out_a=5555 same cycle. Repeat with BYPASS=0 -> old value that cycle, 5555 the next cycle.
- Scoreboard: lock R4 -> busy_a=1 (readnum_a=4), any_busy=1. Write R4=16'h0042 -> busy clears after the edge and data_out_a=0042.
- Lock/write collision: write R5=16'h7777 and lock R5 in the same cycle -> after the edge R5=7777 and busy_a(5)=1. Write R5 and lock R7 together -> R5 busy 0, R7 busy 1.
- ZERO_R0=1: write R0=16'hFFFF and lock R0 -> reads return 0, busy_a=0, any_busy unchanged.
